fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core, directly upstream of the opcode decoder.
- Owns the PC and the next-PC selection (sequential, branch, j/jal, jr).
- Runs a req/ack handshake with instruction memory and drives the IF/ID pipeline register, whose instr[31:26] feeds the decoder's OP input.
- Handles stall, redirect-flush and variable-latency memory.

---
 rtl/mips_fetch_pkg.sv | 18 +
 rtl/next_pc_sel.sv | 39 +++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;
    localparam int unsigned JUMP_INDEX_W       = 26;
    localparam int unsigned PC_INC             = 4;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // REQ: normal fetching; DROP: outstanding request is stale; HOLD: word parked in skid
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect-target priority mux (jr > jump > branch) for the fetch stage.
// Ports:
//   jr, jrAddr             - jr in ID and its rs value
//   jump, jumpIndex        - j/jal in ID and its 26-bit index
//   branchTaken, branchTarget - resolved taken branch and its full target
//   pc4Region              - upper nibble of IF/ID PC+4 (jump region)
//   redirect_c             - any redirect this cycle
//   target_c               - selected redirect target
//   misalign_c             - jr target had nonzero low bits
module next_pc_sel
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                    jr,
    input  logic [DATA_WIDTH-1:0]   jrAddr,
    input  logic                    jump,
    input  logic [JUMP_INDEX_W-1:0] jumpIndex,
    input  logic                    branchTaken,
    input  logic [DATA_WIDTH-1:0]   branchTarget,
    input  logic [3:0]              pc4Region,
    output logic                    redirect_c,
    output logic [DATA_WIDTH-1:0]   target_c,
    output logic                    misalign_c
);

    always_comb begin
        redirect_c = jr | jump | branchTaken;
        misalign_c = jr & (jrAddr[1:0] != 2'b00);
        target_c   = branchTarget;
        if (jr) begin
            // Low bits are forced to zero; misalign_c reports the bad address.
            target_c = {jrAddr[DATA_WIDTH-1:2], 2'b00};
        end else if (jump) begin
            target_c = {pc4Region, jumpIndex, 2'b00};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, next-PC selection, imem req/ack handshake,
// one-entry skid buffer and the IF/ID pipeline register.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   stall_i                         - ID cannot take a new instruction
//   branch_taken_i/branch_target_i  - taken branch redirect from ID
//   jump_i/jump_index_i             - j/jal redirect from ID
//   jr_i/jr_addr_i                  - jr redirect from ID
//   imem_req_o/imem_addr_o          - fetch request and address
//   imem_ack_i/imem_rdata_i         - fetch completion and instruction word
//   if_id_instr_o/if_id_pc4_o/if_id_valid_o - IF/ID register
//   pc_o                            - architectural fetch PC
//   misalign_o                      - one-cycle pulse for misaligned jr target
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic                    branch_taken_i,
    input  logic [DATA_WIDTH-1:0]   branch_target_i,
    input  logic                    jump_i,
    input  logic [JUMP_INDEX_W-1:0] jump_index_i,
    input  logic                    jr_i,
    input  logic [DATA_WIDTH-1:0]   jr_addr_i,
    output logic                    imem_req_o,
    output logic [DATA_WIDTH-1:0]   imem_addr_o,
    input  logic                    imem_ack_i,
    input  logic [DATA_WIDTH-1:0]   imem_rdata_i,
    output logic [DATA_WIDTH-1:0]   if_id_instr_o,
    output logic [DATA_WIDTH-1:0]   if_id_pc4_o,
    output logic                    if_id_valid_o,
    output logic [DATA_WIDTH-1:0]   pc_o,
    output logic                    misalign_o
);

    fetch_state_e          state, stateNext;
    logic [DATA_WIDTH-1:0] pc, pcNext;
    logic [DATA_WIDTH-1:0] reqAddr, reqAddrNext, reqAddrInc;
    logic [DATA_WIDTH-1:0] skidInstr, skidInstrNext;
    logic [DATA_WIDTH-1:0] skidPc4, skidPc4Next;
    logic [DATA_WIDTH-1:0] instrNext, pc4Next;
    logic                  validNext, misalignNext;
    logic                  redirect, misalign, accept;
    logic [DATA_WIDTH-1:0] target;

    next_pc_sel #(.DATA_WIDTH(DATA_WIDTH)) u_nextPcSel (
        .jr           (jr_i),
        .jrAddr       (jr_addr_i),
        .jump         (jump_i),
        .jumpIndex    (jump_index_i),
        .branchTaken  (branch_taken_i),
        .branchTarget (branch_target_i),
        .pc4Region    (if_id_pc4_o[DATA_WIDTH-1 -: 4]),
        .redirect_c   (redirect),
        .target_c     (target),
        .misalign_c   (misalign)
    );

    assign accept      = !stall_i || !if_id_valid_o;
    assign reqAddrInc  = reqAddr + DATA_WIDTH'(PC_INC);
    assign imem_addr_o = reqAddr;
    assign pc_o        = pc;
    // Request is suppressed in the reset cycle so a pending fetch is dropped at once.
    assign imem_req_o  = !reset && (state != HOLD);

    // State, PC, skid and IF/ID registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= REQ;
            pc            <= RESET_PC;
            reqAddr       <= RESET_PC;
            skidInstr     <= '0;
            skidPc4       <= '0;
            if_id_instr_o <= DATA_WIDTH'(NOP_INSTR);
            if_id_pc4_o   <= '0;
            if_id_valid_o <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            state         <= stateNext;
            pc            <= pcNext;
            reqAddr       <= reqAddrNext;
            skidInstr     <= skidInstrNext;
            skidPc4       <= skidPc4Next;
            if_id_instr_o <= instrNext;
            if_id_pc4_o   <= pc4Next;
            if_id_valid_o <= validNext;
            misalign_o    <= misalignNext;
        end
    end

    // Next-state and datapath selection
    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        reqAddrNext   = reqAddr;
        skidInstrNext = skidInstr;
        skidPc4Next   = skidPc4;
        instrNext     = if_id_instr_o;
        pc4Next       = if_id_pc4_o;
        validNext     = if_id_valid_o;
        misalignNext  = misalign;

        // Any redirect squashes IF/ID, even under stall.
        if (redirect) begin
            instrNext = DATA_WIDTH'(NOP_INSTR);
            validNext = 1'b0;
        end

        unique case (state)
            REQ: begin
                if (imem_ack_i) begin
                    if (redirect) begin
                        pcNext      = target;
                        reqAddrNext = target;
                    end else if (accept) begin
                        instrNext   = imem_rdata_i;
                        pc4Next     = reqAddrInc;
                        validNext   = 1'b1;
                        pcNext      = reqAddrInc;
                        reqAddrNext = reqAddrInc;
                    end else begin
                        skidInstrNext = imem_rdata_i;
                        skidPc4Next   = reqAddrInc;
                        pcNext        = reqAddrInc;
                        stateNext     = HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay stable until the stale request completes.
                    pcNext    = target;
                    stateNext = DROP;
                end
            end
            DROP: begin
                if (redirect) begin
                    pcNext = target;
                end
                if (imem_ack_i) begin
                    reqAddrNext = redirect ? target : pc;
                    stateNext   = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pcNext      = target;
                    reqAddrNext = target;
                    stateNext   = REQ;
                end else if (accept) begin
                    instrNext   = skidInstr;
                    pc4Next     = skidPc4;
                    validNext   = 1'b1;
                    reqAddrNext = pc;
                    stateNext   = REQ;
                end
            end
            default: stateNext = REQ;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [25:0] jump_index_i;
    logic        jr_i;
    logic [31:0] jr_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
    logic [31:0] pc_o;
    logic        misalign_o;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_index_i    (jump_index_i),
        .jr_i            (jr_i),
        .jr_addr_i       (jr_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_pc4_o     (if_id_pc4_o),
        .if_id_valid_o   (if_id_valid_o),
        .pc_o            (pc_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    // Memory behaviour: ack after memLat waiting cycles of an asserted request.
    int memLat = 0;
    int memCnt = 0;
    bit randLat = 0;

    // Reference model: fetch PC, address of the outstanding request, whether that
    // request's data is unwanted, a parked word (at most one) and the IF/ID contents.
    typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } ent_t;
    logic [31:0] mPc, mAddr, mInstr, mPc4;
    bit          mStale, mValid, mMis;
    ent_t        mSkid[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic bit modelReq();
        return !reset && (mSkid.size() == 0);
    endfunction

    task automatic model_update();
        logic [31:0] tgt;
        bit redir, acc;
        ent_t e;
        if (reset) begin
            mPc = RST_PC; mAddr = RST_PC; mStale = 0; mSkid.delete();
            mInstr = 0; mPc4 = 0; mValid = 0; mMis = 0;
            return;
        end
        redir = jr_i || jump_i || branch_taken_i;
        if (jr_i)        tgt = {jr_addr_i[31:2], 2'b00};
        else if (jump_i) tgt = {mPc4[31:28], jump_index_i, 2'b00};
        else             tgt = branch_target_i;
        acc  = !stall_i || !mValid;
        mMis = jr_i && (jr_addr_i[1:0] != 2'b00);
        if (redir) begin mValid = 0; mInstr = 0; end
        if (mSkid.size() > 0) begin
            if (redir) begin mSkid.delete(); mPc = tgt; mAddr = tgt; end
            else if (acc) begin
                e = mSkid.pop_front();
                mInstr = e.instr; mPc4 = e.pc4; mValid = 1; mAddr = mPc;
            end
        end else if (mStale) begin
            if (redir) mPc = tgt;
            if (imem_ack_i) begin mStale = 0; mAddr = mPc; end
        end else if (imem_ack_i) begin
            if (redir) begin mPc = tgt; mAddr = tgt; end
            else if (acc) begin
                mInstr = imem_rdata_i; mPc4 = mAddr + 32'd4; mValid = 1;
                mAddr = mAddr + 32'd4; mPc = mAddr;
            end else begin
                e.instr = imem_rdata_i; e.pc4 = mAddr + 32'd4;
                mSkid.push_back(e); mPc = mAddr + 32'd4;
            end
        end else if (redir) begin
            mPc = tgt; mStale = 1;
        end
    endtask

    // One clock: present memory response, advance model, sample after negedge.
    task automatic tick();
        bit r;
        r = modelReq();
        imem_ack_i   = r && (memCnt >= memLat);
        imem_rdata_i = imem_ack_i ? memWord(mAddr) : 32'h0;
        model_update();
        @(posedge clk);
        @(negedge clk);
        if (!r || imem_ack_i) begin
            memCnt = 0;
            if (randLat && imem_ack_i) memLat = $urandom_range(0, 3);
        end else begin
            memCnt++;
        end
    endtask

    task automatic clear_redirects();
        jr_i = 0; jump_i = 0; branch_taken_i = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        #1;
        nVec++; if (imem_req_o !== 1'b0) begin nErr++; $display("FAIL rst_req got=%b exp=0", imem_req_o); end
        tick(); tick();
        nVec++; if (pc_o !== RST_PC) begin nErr++; $display("FAIL rst_pc got=%h exp=%h", pc_o, RST_PC); end
        nVec++; if (imem_addr_o !== RST_PC) begin nErr++; $display("FAIL rst_addr got=%h exp=%h", imem_addr_o, RST_PC); end
        nVec++; if (if_id_valid_o !== 1'b0) begin nErr++; $display("FAIL rst_valid got=%b exp=0", if_id_valid_o); end
        nVec++; if (if_id_instr_o !== 32'h0) begin nErr++; $display("FAIL rst_instr got=%h exp=0", if_id_instr_o); end
        nVec++; if (if_id_pc4_o !== 32'h0) begin nErr++; $display("FAIL rst_pc4 got=%h exp=0", if_id_pc4_o); end
        nVec++; if (misalign_o !== 1'b0) begin nErr++; $display("FAIL rst_mis got=%b exp=0", misalign_o); end
        reset = 0;
        #1;
        nVec++; if (imem_req_o !== 1'b1) begin nErr++; $display("FAIL first_req got=%b exp=1", imem_req_o); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        memLat = 0;
        for (int k = 0; k < 3; k++) begin
            a = RST_PC + 32'(4 * k);
            tick();
            nVec++; if (if_id_pc4_o !== a + 32'd4) begin nErr++; $display("FAIL zw_pc4 got=%h exp=%h", if_id_pc4_o, a + 32'd4); end
            nVec++; if (if_id_valid_o !== 1'b1) begin nErr++; $display("FAIL zw_valid got=%b exp=1", if_id_valid_o); end
            nVec++; if (if_id_instr_o !== memWord(a)) begin nErr++; $display("FAIL zw_instr got=%h exp=%h", if_id_instr_o, memWord(a)); end
        end
    endtask

    task automatic test_latency();
        logic [31:0] expPc4, expAddr;
        memLat = 3;
        expPc4 = 32'h0040_000C;
        for (int i = 0; i < 8; i++) begin
            expAddr = 32'h0040_000C + 32'(4 * (i / 4));
            nVec++; if (imem_addr_o !== expAddr) begin nErr++; $display("FAIL lat_addr got=%h exp=%h", imem_addr_o, expAddr); end
            tick();
            if (i % 4 == 3) expPc4 = expPc4 + 32'd4;
            nVec++; if (if_id_pc4_o !== expPc4) begin nErr++; $display("FAIL lat_pc4 got=%h exp=%h", if_id_pc4_o, expPc4); end
        end
    endtask

    task automatic test_stall();
        memLat = 0;
        stall_i = 1;
        tick();
        for (int i = 0; i < 2; i++) begin
            nVec++; if (imem_req_o !== 1'b0) begin nErr++; $display("FAIL hold_req got=%b exp=0", imem_req_o); end
            nVec++; if (if_id_pc4_o !== 32'h0040_0014) begin nErr++; $display("FAIL hold_pc4 got=%h exp=00400014", if_id_pc4_o); end
            if (i == 0) tick();
        end
        stall_i = 0;
        tick();
        nVec++; if (if_id_pc4_o !== 32'h0040_0018) begin nErr++; $display("FAIL skid_pc4 got=%h exp=00400018", if_id_pc4_o); end
        nVec++; if (if_id_instr_o !== memWord(32'h0040_0014)) begin nErr++; $display("FAIL skid_instr got=%h exp=%h", if_id_instr_o, memWord(32'h0040_0014)); end
        nVec++; if (imem_req_o !== 1'b1) begin nErr++; $display("FAIL resume_req got=%b exp=1", imem_req_o); end
        nVec++; if (imem_addr_o !== 32'h0040_0018) begin nErr++; $display("FAIL resume_addr got=%h exp=00400018", imem_addr_o); end
        tick();
        nVec++; if (if_id_pc4_o !== 32'h0040_001C) begin nErr++; $display("FAIL resume_pc4 got=%h exp=0040001c", if_id_pc4_o); end
    endtask

    task automatic test_jump_drop();
        reset = 1; tick(); reset = 0;
        memLat = 0; tick(); tick();
        nVec++; if (if_id_pc4_o !== 32'h0040_0008) begin nErr++; $display("FAIL jd_pre_pc4 got=%h exp=00400008", if_id_pc4_o); end
        memLat = 2;
        jump_i = 1; jump_index_i = 26'h000_0010;
        tick();
        clear_redirects();
        nVec++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin nErr++; $display("FAIL jd_flush got=%b/%h exp=0/0", if_id_valid_o, if_id_instr_o); end
        nVec++; if (pc_o !== 32'h0000_0040) begin nErr++; $display("FAIL jd_pc got=%h exp=00000040", pc_o); end
        for (int i = 0; i < 2; i++) begin
            nVec++; if (imem_addr_o !== 32'h0040_0008 || imem_req_o !== 1'b1) begin nErr++; $display("FAIL jd_hold_addr got=%h req=%b exp=00400008 req=1", imem_addr_o, imem_req_o); end
            tick();
        end
        nVec++; if (imem_addr_o !== 32'h0000_0040) begin nErr++; $display("FAIL jd_new_addr got=%h exp=00000040", imem_addr_o); end
        nVec++; if (if_id_valid_o !== 1'b0) begin nErr++; $display("FAIL jd_discard got=%b exp=0", if_id_valid_o); end
        memLat = 0; tick();
        nVec++; if (if_id_instr_o !== memWord(32'h40) || if_id_pc4_o !== 32'h44) begin nErr++; $display("FAIL jd_refetch got=%h/%h exp=%h/00000044", if_id_instr_o, if_id_pc4_o, memWord(32'h40)); end
    endtask

    task automatic test_jr_priority();
        memLat = 0;
        jr_i = 1; jr_addr_i = 32'h0040_0013;
        jump_i = 1; jump_index_i = 26'h3FF_FFFF;
        branch_taken_i = 1; branch_target_i = 32'h1234_5678;
        tick();
        clear_redirects();
        nVec++; if (imem_addr_o !== 32'h0040_0010) begin nErr++; $display("FAIL jr_addr got=%h exp=00400010", imem_addr_o); end
        nVec++; if (misalign_o !== 1'b1) begin nErr++; $display("FAIL jr_mis got=%b exp=1", misalign_o); end
        nVec++; if (if_id_valid_o !== 1'b0) begin nErr++; $display("FAIL jr_flush got=%b exp=0", if_id_valid_o); end
        tick();
        nVec++; if (misalign_o !== 1'b0) begin nErr++; $display("FAIL jr_mis_pulse got=%b exp=0", misalign_o); end
        nVec++; if (if_id_pc4_o !== 32'h0040_0014) begin nErr++; $display("FAIL jr_pc4 got=%h exp=00400014", if_id_pc4_o); end
    endtask

    task automatic test_wrap_reset();
        memLat = 0;
        jr_i = 1; jr_addr_i = 32'hFFFF_FFFC;
        tick();
        clear_redirects();
        nVec++; if (imem_addr_o !== 32'hFFFF_FFFC) begin nErr++; $display("FAIL wrap_pre got=%h exp=fffffffc", imem_addr_o); end
        tick();
        nVec++; if (imem_addr_o !== 32'h0) begin nErr++; $display("FAIL wrap_addr got=%h exp=0", imem_addr_o); end
        nVec++; if (if_id_pc4_o !== 32'h0 || if_id_valid_o !== 1'b1) begin nErr++; $display("FAIL wrap_pc4 got=%h/%b exp=0/1", if_id_pc4_o, if_id_valid_o); end
        memLat = 3; tick();
        reset = 1;
        #1;
        nVec++; if (imem_req_o !== 1'b0) begin nErr++; $display("FAIL midrst_req got=%b exp=0", imem_req_o); end
        tick();
        reset = 0;
        nVec++; if (if_id_valid_o !== 1'b0) begin nErr++; $display("FAIL midrst_valid got=%b exp=0", if_id_valid_o); end
        nVec++; if (pc_o !== RST_PC) begin nErr++; $display("FAIL midrst_pc got=%h exp=%h", pc_o, RST_PC); end
    endtask

    task automatic test_random();
        int r;
        reset = 1; tick(); reset = 0;
        randLat = 1; memLat = $urandom_range(0, 3);
        for (int c = 0; c < 600; c++) begin
            stall_i = ($urandom_range(0, 99) < 30);
            r = $urandom_range(0, 99);
            jr_i = (r < 4) || (r == 20);
            jump_i = (r >= 4 && r < 9) || (r == 20);
            branch_taken_i = (r >= 9 && r < 15) || (r == 20);
            jr_addr_i = $urandom();
            jump_index_i = 26'($urandom());
            branch_target_i = $urandom();
            reset = ($urandom_range(0, 99) == 0);
            tick();
            nVec++; if (imem_req_o !== modelReq()) begin nErr++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req_o, modelReq()); end
            nVec++; if (imem_addr_o !== mAddr) begin nErr++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr_o, mAddr); end
            nVec++; if (pc_o !== mPc) begin nErr++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, pc_o, mPc); end
            nVec++; if (if_id_instr_o !== mInstr) begin nErr++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, if_id_instr_o, mInstr); end
            nVec++; if (if_id_pc4_o !== mPc4) begin nErr++; $display("FAIL rnd_pc4 c=%0d got=%h exp=%h", c, if_id_pc4_o, mPc4); end
            nVec++; if (if_id_valid_o !== mValid) begin nErr++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, if_id_valid_o, mValid); end
            nVec++; if (misalign_o !== mMis) begin nErr++; $display("FAIL rnd_mis c=%0d got=%b exp=%b", c, misalign_o, mMis); end
        end
        clear_redirects();
        stall_i = 0; reset = 0; randLat = 0;
    endtask

    initial begin
        reset = 1; stall_i = 0;
        branch_taken_i = 0; branch_target_i = 0;
        jump_i = 0; jump_index_i = 0;
        jr_i = 0; jr_addr_i = 0;
        imem_ack_i = 0; imem_rdata_i = 0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_jump_drop();
        test_jr_priority();
        test_wrap_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
